// File: rtl/stack_pointer_unit.sv
// -----------------------------------------------------------------------------
// stack_pointer_unit
//
// Stack pointer with bounds checking, sticky overflow/underflow flags and a
// burst engine for multi-word context save/restore (interrupt entry/exit,
// CALL with a wide return address). The unit owns SP and drives the stack
// memory address and strobes directly. A push pre-decrements SP; a pop
// post-increments it. The stack grows downward from RESET_SP (empty) to
// STACK_LIMIT (full).
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_sp_load_en  load SP from i_sp_load (highest priority, aborts a burst)
//   i_sp_load     value to load into SP
//   i_push        single-word push request
//   i_pop         single-word pop request
//   i_burst_push  start a burst push of i_burst_len words
//   i_burst_pop   start a burst pop of i_burst_len words
//   i_burst_len   words in a burst; 0 = no-op, > MAX_BURST clamps to MAX_BURST
//   i_flag_clr    clear both sticky flags
//   o_sp          current stack pointer
//   o_mem_addr    stack memory address (registered)
//   o_mem_we      write strobe, one cycle per pushed word
//   o_mem_re      read strobe, one cycle per popped word
//   o_busy        burst in progress
//   o_empty       SP >= RESET_SP
//   o_full        SP <= STACK_LIMIT
//   o_overflow    sticky: push or burst push rejected for lack of space
//   o_underflow   sticky: pop or burst pop rejected for lack of data
// -----------------------------------------------------------------------------
module stack_pointer_unit #(
    parameter int unsigned   AW          = 8,
    parameter logic [AW-1:0] RESET_SP    = 'hFF,
    parameter logic [AW-1:0] STACK_LIMIT = 'hC0,
    parameter int unsigned   MAX_BURST   = 4,
    parameter int unsigned   BLW         = 3
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_sp_load_en,
    input  logic [AW-1:0]  i_sp_load,
    input  logic           i_push,
    input  logic           i_pop,
    input  logic           i_burst_push,
    input  logic           i_burst_pop,
    input  logic [BLW-1:0] i_burst_len,
    input  logic           i_flag_clr,
    output logic [AW-1:0]  o_sp,
    output logic [AW-1:0]  o_mem_addr,
    output logic           o_mem_we,
    output logic           o_mem_re,
    output logic           o_busy,
    output logic           o_empty,
    output logic           o_full,
    output logic           o_overflow,
    output logic           o_underflow
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBpush = 2'd1,
        StBpop  = 2'd2
    } state_e;

    localparam logic [BLW-1:0] MaxLen = BLW'(MAX_BURST);
    localparam logic [BLW-1:0] OneLen = BLW'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e         r_state,    w_state_d;
    logic [AW-1:0]  r_sp,       w_sp_d;
    logic [AW-1:0]  r_mem_addr, w_mem_addr_d;
    logic           r_mem_we,   w_mem_we_d;
    logic           r_mem_re,   w_mem_re_d;
    logic [BLW-1:0] r_cnt,      w_cnt_d;
    logic           r_ovf,      w_ovf_d;
    logic           r_unf,      w_unf_d;

    // -------------------------------------------------------------------------
    // Occupancy and burst length
    // -------------------------------------------------------------------------
    logic [AW-1:0]  w_free;
    logic [AW-1:0]  w_used;
    logic [BLW-1:0] w_len;
    logic [AW-1:0]  w_len_aw;
    logic           w_len_nz;
    logic           w_len_multi;
    logic           w_ovf_set;
    logic           w_unf_set;

    // Both are modulo 2^AW; only meaningful while SP is inside the stack region.
    assign w_free = r_sp - STACK_LIMIT;
    assign w_used = RESET_SP - r_sp;

    assign w_len       = (i_burst_len > MaxLen) ? MaxLen : i_burst_len;
    assign w_len_aw    = AW'(w_len);
    assign w_len_nz    = (w_len != '0);
    assign w_len_multi = (w_len > OneLen);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state;
        w_sp_d       = r_sp;
        w_mem_addr_d = r_mem_addr;
        w_mem_we_d   = 1'b0;
        w_mem_re_d   = 1'b0;
        w_cnt_d      = r_cnt;
        w_ovf_set    = 1'b0;
        w_unf_set    = 1'b0;

        if (i_sp_load_en) begin
            // Load wins over everything and abandons any burst in flight.
            w_sp_d    = i_sp_load;
            w_state_d = StIdle;
            w_cnt_d   = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_burst_push && !i_burst_pop) begin
                        if (w_len_nz) begin
                            if (w_free >= w_len_aw) begin
                                // The accepting edge already moves the first word.
                                w_sp_d       = r_sp - 1'b1;
                                w_mem_addr_d = r_sp - 1'b1;
                                w_mem_we_d   = 1'b1;
                                w_cnt_d      = w_len - OneLen;
                                w_state_d    = w_len_multi ? StBpush : StIdle;
                            end else begin
                                w_ovf_set = 1'b1;
                            end
                        end
                    end else if (i_burst_pop && !i_burst_push) begin
                        if (w_len_nz) begin
                            if (w_used >= w_len_aw) begin
                                w_mem_addr_d = r_sp;
                                w_sp_d       = r_sp + 1'b1;
                                w_mem_re_d   = 1'b1;
                                w_cnt_d      = w_len - OneLen;
                                w_state_d    = w_len_multi ? StBpop : StIdle;
                            end else begin
                                w_unf_set = 1'b1;
                            end
                        end
                    end else if (!i_burst_push && !i_burst_pop) begin
                        // A simultaneous push and pop falls through as a no-op.
                        if (i_push && !i_pop) begin
                            if (w_free != '0) begin
                                w_sp_d       = r_sp - 1'b1;
                                w_mem_addr_d = r_sp - 1'b1;
                                w_mem_we_d   = 1'b1;
                            end else begin
                                w_ovf_set = 1'b1;
                            end
                        end else if (i_pop && !i_push) begin
                            if (w_used != '0) begin
                                w_mem_addr_d = r_sp;
                                w_sp_d       = r_sp + 1'b1;
                                w_mem_re_d   = 1'b1;
                            end else begin
                                w_unf_set = 1'b1;
                            end
                        end
                    end
                end

                // r_cnt holds the words still to move, including this cycle's.
                StBpush: begin
                    w_sp_d       = r_sp - 1'b1;
                    w_mem_addr_d = r_sp - 1'b1;
                    w_mem_we_d   = 1'b1;
                    w_cnt_d      = r_cnt - OneLen;
                    if (r_cnt <= OneLen) begin
                        w_state_d = StIdle;
                    end
                end

                StBpop: begin
                    w_mem_addr_d = r_sp;
                    w_sp_d       = r_sp + 1'b1;
                    w_mem_re_d   = 1'b1;
                    w_cnt_d      = r_cnt - OneLen;
                    if (r_cnt <= OneLen) begin
                        w_state_d = StIdle;
                    end
                end

                default: begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end
            endcase
        end

        // A flag being set in the same cycle as a clear stays set.
        w_ovf_d = w_ovf_set | (r_ovf & ~i_flag_clr);
        w_unf_d = w_unf_set | (r_unf & ~i_flag_clr);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_sp       <= RESET_SP;
            r_mem_addr <= '0;
            r_mem_we   <= 1'b0;
            r_mem_re   <= 1'b0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_sp       <= w_sp_d;
            r_mem_addr <= w_mem_addr_d;
            r_mem_we   <= w_mem_we_d;
            r_mem_re   <= w_mem_re_d;
            r_cnt      <= w_cnt_d;
            r_ovf      <= w_ovf_d;
            r_unf      <= w_unf_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_sp        = r_sp;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_we    = r_mem_we;
    assign o_mem_re    = r_mem_re;
    assign o_busy      = (r_state != StIdle);
    assign o_empty     = (r_sp >= RESET_SP);
    assign o_full      = (r_sp <= STACK_LIMIT);
    assign o_overflow  = r_ovf;
    assign o_underflow = r_unf;

endmodule
